// File: rtl/add32_pkg.sv
// Shared types and constants for the add_sub32_seq slice.
// State encoding, operand widths and the add/sub op code.
package add32_pkg;

  localparam int WIDTH = 32;
  localparam int HALF  = 16;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/add_sub32_seq_rca16.sv
// 16-bit carry-select adder shared by both passes of add_sub32_seq.
// Upper byte is precomputed for both carries and picked by the low carry.
module RCA_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [8:0] lo;
  logic [8:0] hi0;
  logic [8:0] hi1;

  assign lo  = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, cin};
  assign hi0 = {1'b0, a[15:8]} + {1'b0, b[15:8]};
  assign hi1 = hi0 + 9'd1;

  assign sum[7:0]  = lo[7:0];
  assign sum[15:8] = lo[8] ? hi1[7:0] : hi0[7:0];
  assign cout      = lo[8] ? hi1[8] : hi0[8];

endmodule

// File: rtl/add_sub32_seq.sv
// Two-pass 32-bit add/sub over one 16-bit adder, low half first.
// Define ADD32_OVF_EN to register signed overflow; otherwise it is 0.
module add_sub32_seq #(
  parameter int WIDTH = add32_pkg::WIDTH,
  parameter int HALF  = add32_pkg::HALF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  import add32_pkg::*;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic             c16;
  logic             accept;
  logic [HALF-1:0]  add_a;
  logic [HALF-1:0]  add_b;
  logic [HALF-1:0]  add_s;
  logic             add_ci;
  logic             add_co;
  logic             hi_pass;

  assign in_ready = (state == IDLE) ||
                    ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign hi_pass  = (state == HIGH);

  assign add_a  = hi_pass ? a_q[WIDTH-1:HALF] : a_q[HALF-1:0];
  assign add_b  = hi_pass ? b_q[WIDTH-1:HALF] : b_q[HALF-1:0];
  assign add_ci = hi_pass ? c16 : cin_q;

  RCA_16bit u_rca (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_ci),
    .sum  (add_s),
    .cout (add_co)
  );

  // Operand capture, pass sequencing and result assembly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      c16       <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= a;
        b_q   <= (sub == SUB) ? ~b : b;
        cin_q <= (sub == SUB);
      end
      unique case (state)
        IDLE: begin
          if (accept) state <= LOW;
        end
        LOW: begin
          result[HALF-1:0] <= add_s;
          c16              <= add_co;
          state            <= HIGH;
        end
        HIGH: begin
          result[WIDTH-1:HALF] <= add_s;
          cout                 <= add_co;
          out_valid            <= 1'b1;
          state                <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= in_valid ? LOW : IDLE;
          end
        end
      endcase
    end
  end

`ifdef ADD32_OVF_EN
  // Signed overflow from the sign bits seen on the high pass.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (hi_pass) begin
      overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                  (add_s[HALF-1] != a_q[WIDTH-1]);
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule
